rp_sd_arbiter: RTL and testbench

//   Round-robin scheduler that shares the single SD controller among the eight

---
 rtl/rp_sd_arbiter.sv | 110 +++++++++++
 tb/tb_rp_sd_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rp_sd_arbiter.sv
// rp_sd_arbiter: round-robin grant of the shared SD controller to eight RPxx drives
module rp_sd_arbiter #(
    parameter int TOWIDTH = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [7:0]   rpSDREQ,
    input  logic [23:0]  rpSDOPALL,
    input  logic [167:0] rpSDLSAALL,
    input  logic         sdDONE,
    output logic [7:0]   rpSDACK,
    output logic [2:0]   arbSCAN,
    output logic [2:0]   arbSDOP,
    output logic [20:0]  arbSDLSA,
    output logic         arbSTART,
    output logic         arbBUSY,
    output logic         arbTIMEOUT
);
    typedef enum logic [1:0] {IDLE, START, BUSY, ACK} state_t;
    state_t state, nState;
    logic [2:0] ptr, nPtr, idx, nScan, nOp;
    logic [20:0] nLsa;
    logic [7:0] nAck;
    logic nStart, nBusy, nTimeout, found;
    logic [TOWIDTH-1:0] timer, nTimer;
    always_comb begin
        idx = ptr;
        found = 1'b0;
        for (int i = 0; i < 8; i++)
            if (!found && rpSDREQ[ptr + 3'(i)]) begin
                idx = ptr + 3'(i);
                found = 1'b1;
            end
    end
    // timer runs from the grant edge, so it reads all-ones on the 15th (2**TOWIDTH-1) BUSY cycle
    always_comb begin
        nState = state;
        nPtr = ptr;
        nScan = arbSCAN;
        nOp = arbSDOP;
        nLsa = arbSDLSA;
        nAck = '0;
        nStart = 1'b0;
        nBusy = arbBUSY;
        nTimeout = arbTIMEOUT;
        nTimer = timer;
        case (state)
            IDLE: if (found) begin
                nState = START;
                nScan = idx;
                nOp = rpSDOPALL[3*idx +: 3];
                nLsa = rpSDLSAALL[21*idx +: 21];
                nBusy = 1'b1;
                nStart = 1'b1;
                nTimer = '0;
            end
            START: begin
                nState = BUSY;
                nTimer = timer + 1'b1;
            end
            BUSY: begin
                nTimer = timer + 1'b1;
                if (sdDONE || &timer) begin
                    nState = ACK;
                    nAck = 8'b1 << arbSCAN;
                    nPtr = arbSCAN + 3'd1;
                    nTimeout = arbTIMEOUT | ~sdDONE;
                end
            end
            ACK: begin
                nState = IDLE;
                nBusy = 1'b0;
            end
            default: nState = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        if (!rst) begin
            state <= IDLE;
            ptr <= '0;
            arbSCAN <= '0;
            arbSDOP <= '0;
            arbSDLSA <= '0;
            timer <= '0;
            rpSDACK <= '0;
            arbSTART <= 1'b0;
            arbBUSY <= 1'b0;
            arbTIMEOUT <= 1'b0;
        end else if (clr) begin
            state <= IDLE;
            ptr <= '0;
            timer <= '0;
            rpSDACK <= '0;
            arbSTART <= 1'b0;
            arbBUSY <= 1'b0;
            arbTIMEOUT <= 1'b0;
        end else begin
            state <= nState;
            ptr <= nPtr;
            arbSCAN <= nScan;
            arbSDOP <= nOp;
            arbSDLSA <= nLsa;
            timer <= nTimer;
            rpSDACK <= nAck;
            arbSTART <= nStart;
            arbBUSY <= nBusy;
            arbTIMEOUT <= nTimeout;
        end
endmodule

// File: tb/tb_rp_sd_arbiter.sv
// tb_rp_sd_arbiter: directed scenarios for the round-robin SD arbiter
module tb_rp_sd_arbiter;
    logic clk = 1'b0, rst = 1'b0, clr = 1'b0, sdDONE = 1'b0;
    logic [7:0] rpSDREQ = '0;
    logic [23:0] rpSDOPALL;
    logic [167:0] rpSDLSAALL;
    logic [7:0] rpSDACK;
    logic [2:0] arbSCAN, arbSDOP;
    logic [20:0] arbSDLSA;
    logic arbSTART, arbBUSY, arbTIMEOUT;
    int checks = 0, failures = 0;
    rp_sd_arbiter #(.TOWIDTH(4)) dut (
        .clk(clk), .rst(rst), .clr(clr), .rpSDREQ(rpSDREQ), .rpSDOPALL(rpSDOPALL),
        .rpSDLSAALL(rpSDLSAALL), .sdDONE(sdDONE), .rpSDACK(rpSDACK), .arbSCAN(arbSCAN),
        .arbSDOP(arbSDOP), .arbSDLSA(arbSDLSA), .arbSTART(arbSTART), .arbBUSY(arbBUSY),
        .arbTIMEOUT(arbTIMEOUT)
    );
    always #5 clk = ~clk;
    function automatic logic [2:0] expOp(int i);
        return 3'(7 - i);
    endfunction
    function automatic logic [20:0] expLsa(int i);
        return 21'(i * 4099 + 17);
    endfunction
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic waitStart(output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 12 && !ok; k++) begin
            tick();
            ok = arbSTART;
        end
    endtask
    task automatic test_reset;
        rst = 1'b0;
        rpSDREQ = 8'hFF;
        repeat (3) begin
            tick();
            checks++;
            if ({rpSDACK, arbSCAN, arbSDOP, arbSDLSA, arbSTART, arbBUSY, arbTIMEOUT} !== 39'd0) begin
                failures++;
                $display("FAIL reset_outputs got=%h exp=0", {rpSDACK, arbSCAN, arbSDOP, arbSDLSA, arbSTART, arbBUSY, arbTIMEOUT});
            end
        end
        rpSDREQ = '0;
        rst = 1'b1;
        tick();
        checks++;
        if ({arbBUSY, arbSTART} !== 2'b00) begin
            failures++;
            $display("FAIL reset_release_idle got=%b exp=00", {arbBUSY, arbSTART});
        end
    endtask
    task automatic test_single;
        rpSDREQ = 8'h08;
        tick();
        checks++;
        if ({arbSCAN, arbBUSY, arbSTART} !== {3'd3, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL single_grant got scan=%0d busy=%b start=%b exp 3 1 1", arbSCAN, arbBUSY, arbSTART);
        end
        checks++;
        if ({arbSDOP, arbSDLSA} !== {expOp(3), expLsa(3)}) begin
            failures++;
            $display("FAIL single_latch got op=%0d lsa=%0d exp op=%0d lsa=%0d", arbSDOP, arbSDLSA, expOp(3), expLsa(3));
        end
        rpSDOPALL[11:9] = ~expOp(3);
        rpSDLSAALL[83:63] = 21'h1FFFFF;
        tick();
        checks++;
        if ({arbSTART, arbSDOP, arbSDLSA} !== {1'b0, expOp(3), expLsa(3)}) begin
            failures++;
            $display("FAIL single_busy_stable got start=%b op=%0d lsa=%0d exp 0 %0d %0d", arbSTART, arbSDOP, arbSDLSA, expOp(3), expLsa(3));
        end
        rpSDOPALL[11:9] = expOp(3);
        rpSDLSAALL[83:63] = expLsa(3);
        sdDONE = 1'b1;
        tick();
        sdDONE = 1'b0;
        checks++;
        if ({rpSDACK, arbBUSY} !== {8'h08, 1'b1}) begin
            failures++;
            $display("FAIL single_ack got ack=%h busy=%b exp 08 1", rpSDACK, arbBUSY);
        end
        rpSDREQ = '0;
        tick();
        checks++;
        if ({rpSDACK, arbBUSY, arbSTART} !== 10'd0) begin
            failures++;
            $display("FAIL single_release got ack=%h busy=%b start=%b exp 00 0 0", rpSDACK, arbBUSY, arbSTART);
        end
    endtask
    task automatic test_fairness;
        logic ok;
        logic [7:0] e;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        rpSDREQ = 8'hFF;
        for (int n = 0; n < 9; n++) begin
            waitStart(ok);
            checks++;
            if (!ok || arbSCAN !== 3'(n % 8)) begin
                failures++;
                $display("FAIL fair_grant%0d got started=%b scan=%0d exp scan=%0d", n, ok, arbSCAN, n % 8);
            end
            repeat (4) tick();
            sdDONE = 1'b1;
            tick();
            sdDONE = 1'b0;
            e = 8'b1 << (n % 8);
            checks++;
            if (rpSDACK !== e) begin
                failures++;
                $display("FAIL fair_ack%0d got=%h exp=%h", n, rpSDACK, e);
            end
        end
        rpSDREQ = '0;
        tick();
    endtask
    task automatic test_wrap;
        logic ok;
        logic [7:0] e;
        logic [2:0] exps [3] = '{3'd5, 3'd0, 3'd5};
        logic [7:0] after [3] = '{8'h21, 8'h20, 8'h00};
        rpSDREQ = 8'h20;
        for (int n = 0; n < 3; n++) begin
            waitStart(ok);
            checks++;
            if (!ok || arbSCAN !== exps[n]) begin
                failures++;
                $display("FAIL wrap_grant%0d got started=%b scan=%0d exp scan=%0d", n, ok, arbSCAN, exps[n]);
            end
            tick();
            sdDONE = 1'b1;
            tick();
            sdDONE = 1'b0;
            e = 8'b1 << exps[n];
            checks++;
            if (rpSDACK !== e) begin
                failures++;
                $display("FAIL wrap_ack%0d got=%h exp=%h", n, rpSDACK, e);
            end
            rpSDREQ = after[n];
        end
        tick();
    endtask
    task automatic test_timeout;
        logic ok;
        rpSDREQ = 8'h04;
        waitStart(ok);
        repeat (15) tick();
        checks++;
        if (!ok || {arbSCAN, arbBUSY, rpSDACK, arbTIMEOUT} !== {3'd2, 1'b1, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL timeout_pending got started=%b scan=%0d busy=%b ack=%h to=%b exp 1 2 1 00 0", ok, arbSCAN, arbBUSY, rpSDACK, arbTIMEOUT);
        end
        tick();
        checks++;
        if ({rpSDACK, arbTIMEOUT} !== {8'h04, 1'b1}) begin
            failures++;
            $display("FAIL timeout_fire got ack=%h to=%b exp 04 1", rpSDACK, arbTIMEOUT);
        end
        rpSDREQ = '0;
        tick();
        checks++;
        if ({rpSDACK, arbBUSY, arbTIMEOUT} !== {8'h00, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL timeout_sticky got ack=%h busy=%b to=%b exp 00 0 1", rpSDACK, arbBUSY, arbTIMEOUT);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (arbTIMEOUT !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clr got=%b exp=0", arbTIMEOUT);
        end
        rpSDREQ = 8'h04;
        waitStart(ok);
        repeat (15) tick();
        sdDONE = 1'b1;
        tick();
        sdDONE = 1'b0;
        checks++;
        if (!ok || {rpSDACK, arbTIMEOUT} !== {8'h04, 1'b0}) begin
            failures++;
            $display("FAIL timeout_coincident got started=%b ack=%h to=%b exp 1 04 0", ok, rpSDACK, arbTIMEOUT);
        end
        rpSDREQ = '0;
        tick();
    endtask
    task automatic test_abort;
        logic ok;
        rpSDREQ = 8'h02;
        waitStart(ok);
        checks++;
        if (!ok || arbSCAN !== 3'd1) begin
            failures++;
            $display("FAIL abort_grant got started=%b scan=%0d exp scan=1", ok, arbSCAN);
        end
        repeat (2) tick();
        clr = 1'b1;
        rpSDREQ = '0;
        tick();
        clr = 1'b0;
        checks++;
        if ({arbBUSY, arbSTART, rpSDACK, arbSCAN} !== {1'b0, 1'b0, 8'h00, 3'd1}) begin
            failures++;
            $display("FAIL abort_idle got busy=%b start=%b ack=%h scan=%0d exp 0 0 00 1", arbBUSY, arbSTART, rpSDACK, arbSCAN);
        end
        sdDONE = 1'b1;
        tick();
        sdDONE = 1'b0;
        tick();
        checks++;
        if ({rpSDACK, arbBUSY} !== 9'd0) begin
            failures++;
            $display("FAIL abort_late_done got ack=%h busy=%b exp 00 0", rpSDACK, arbBUSY);
        end
        rpSDREQ = 8'h81;
        waitStart(ok);
        checks++;
        if (!ok || {arbSCAN, arbSDOP, arbSDLSA} !== {3'd0, expOp(0), expLsa(0)}) begin
            failures++;
            $display("FAIL abort_regrant got started=%b scan=%0d op=%0d lsa=%0d exp 1 0 %0d %0d", ok, arbSCAN, arbSDOP, arbSDLSA, expOp(0), expLsa(0));
        end
        tick();
        sdDONE = 1'b1;
        tick();
        sdDONE = 1'b0;
        checks++;
        if (rpSDACK !== 8'h01) begin
            failures++;
            $display("FAIL abort_regrant_ack got=%h exp=01", rpSDACK);
        end
        rpSDREQ = '0;
        tick();
    endtask
    initial begin
        for (int i = 0; i < 8; i++) begin
            rpSDOPALL[3*i +: 3] = expOp(i);
            rpSDLSAALL[21*i +: 21] = expLsa(i);
        end
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_timeout();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
